// File: rtl/rca_config_sequencer.sv
// RCA configuration sequencer: expands one command into RCA config/use words.
// Optional LS_MASK config word enabled by macro RCA_CFG_LS_MASK_EN.
module rca_config_sequencer #(
  parameter int GRID_COUNT_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_slot,
  input  logic [6:0]              cmd_mask,
  input  logic [GRID_COUNT_W-1:0] cmd_grid_count,
  input  logic [4:0]              cmd_base_reg,
  input  logic                    cmd_use,
  input  logic                    cmd_use_fb,
  input  logic [4:0]              cmd_rd,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [31:0]             instr,
  output logic                    instr_last,
  output logic                    busy,
  output logic                    done
);

  localparam logic [6:0] OPC = 7'b0101011;
  localparam int GW = GRID_COUNT_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      pend_q, pend_d;
  logic [GW-1:0]   grid_q, grid_d;
  logic [4:0]      ptr_q, ptr_d;
  logic [4:0]      base_q, rd_q;
  logic [1:0]      slot_q;
  logic            fb_q;

  logic [6:0]      mask_eff;
  logic [7:0]      pend_init;
  logic [2:0]      cur;
  logic            grid_more;
  logic            last_word;
  logic            accept;
  logic            fire;
  logic [31:0]     word;

`ifdef RCA_CFG_LS_MASK_EN
  assign mask_eff = cmd_mask;
`else
  assign mask_eff = cmd_mask & 7'h3F;
`endif

  assign pend_init = {cmd_use, mask_eff};
  assign accept    = cmd_valid && (state_q == IDLE);
  assign fire      = (state_q == EMIT) && instr_ready;

  // Bit 7 of pend is the trailing use word.
  always_comb begin
    cur = '0;
    for (int i = 7; i >= 0; i--) begin
      if (pend_q[i]) cur = 3'(i);
    end
  end

  assign grid_more = (cur == 3'd1) && (grid_q > GW'(1));
  assign last_word = ((pend_q & ~(8'd1 << cur)) == 8'd0) && !grid_more;

  always_comb begin
    if (cur == 3'd7) begin
      word = {6'd0, ~fb_q, base_q + 5'd1, base_q,
              1'b0, slot_q, rd_q, OPC};
    end else begin
      word = {7'd2 + {4'd0, cur}, ptr_q + 5'd1, ptr_q,
              1'b0, slot_q, 5'd0, OPC};
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    grid_d  = grid_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          pend_d  = pend_init;
          grid_d  = {(cmd_grid_count == '0), cmd_grid_count};
          ptr_d   = cmd_base_reg;
          state_d = (pend_init == 8'd0) ? DONE : EMIT;
        end
      end
      EMIT: begin
        if (fire) begin
          if (cur != 3'd7) ptr_d = ptr_q + 5'd2;
          if (grid_more) begin
            grid_d = grid_q - GW'(1);
          end else begin
            pend_d = pend_q & ~(8'd1 << cur);
          end
          if (last_word) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      grid_q  <= '0;
      ptr_q   <= '0;
      base_q  <= '0;
      rd_q    <= '0;
      slot_q  <= '0;
      fb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      grid_q  <= grid_d;
      ptr_q   <= ptr_d;
      if (accept) begin
        base_q <= cmd_base_reg;
        rd_q   <= cmd_rd;
        slot_q <= cmd_slot;
        fb_q   <= cmd_use_fb;
      end
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign instr_valid = (state_q == EMIT);
  assign instr       = (state_q == EMIT) ? word : 32'd0;
  assign instr_last  = (state_q == EMIT) && last_word;
  assign busy        = (state_q == EMIT) || (state_q == DONE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_rca_config_sequencer.sv
// Directed self-checking bench for rca_config_sequencer.
// Words are built from hand-derived field values or fixed hex constants.
module tb_rca_config_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_slot;
  logic [6:0]  cmd_mask;
  logic [3:0]  cmd_grid_count;
  logic [4:0]  cmd_base_reg;
  logic        cmd_use;
  logic        cmd_use_fb;
  logic [4:0]  cmd_rd;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        instr_last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [31:0] got[$];
  logic        lastq[$];
  logic        saw_done;

  rca_config_sequencer #(.GRID_COUNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_slot(cmd_slot),
    .cmd_mask(cmd_mask),
    .cmd_grid_count(cmd_grid_count),
    .cmd_base_reg(cmd_base_reg),
    .cmd_use(cmd_use),
    .cmd_use_fb(cmd_use_fb),
    .cmd_rd(cmd_rd),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_last(instr_last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cw(input int f7, input int rs2,
                                     input int rs1, input int f3,
                                     input int rd);
    logic [6:0] a;
    logic [4:0] b;
    logic [4:0] c;
    logic [2:0] d;
    logic [4:0] e;
    a = 7'(f7);
    b = 5'(rs2);
    c = 5'(rs1);
    d = 3'(f3);
    e = 5'(rd);
    return {a, b, c, d, e, 7'b0101011};
  endfunction

  // Returns at the falling edge right after the command handshake.
  task automatic send(input logic [6:0] m, input logic [3:0] gc,
                      input logic [4:0] base, input logic [1:0] slot,
                      input logic use_w, input logic fb,
                      input logic [4:0] rd);
    cmd_mask       = m;
    cmd_grid_count = gc;
    cmd_base_reg   = base;
    cmd_slot       = slot;
    cmd_use        = use_w;
    cmd_use_fb     = fb;
    cmd_rd         = rd;
    cmd_valid      = 1'b1;
    @(negedge clk);
    cmd_valid      = 1'b0;
  endtask

  task automatic collect(input int maxc);
    got.delete();
    lastq.delete();
    saw_done = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      if (done) begin
        saw_done = 1'b1;
        break;
      end
      if (instr_valid) begin
        got.push_back(instr);
        lastq.push_back(instr_last);
      end
      @(negedge clk);
    end
    chk("done_seen", {31'd0, saw_done}, 32'd1);
  endtask

  initial begin
    logic hit_v;
    logic hit_d;
    rst            = 1'b1;
    cmd_valid      = 1'b0;
    cmd_mask       = '0;
    cmd_grid_count = '0;
    cmd_base_reg   = '0;
    cmd_slot       = '0;
    cmd_use        = 1'b0;
    cmd_use_fb     = 1'b0;
    cmd_rd         = '0;
    instr_ready    = 1'b1;

    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_last", {31'd0, instr_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single CPU_REG word
    send(7'b0000001, 4'd0, 5'd5, 2'd2, 1'b0, 1'b0, 5'd0);
    chk("t1_valid", {31'd0, instr_valid}, 32'd1);
    chk("t1_instr", instr, 32'h0462A02B);
    chk("t1_last", {31'd0, instr_last}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_valid_off", {31'd0, instr_valid}, 32'd0);
    chk("t1_busy_done", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("t1_done_off", {31'd0, done}, 32'd0);
    chk("t1_idle", {31'd0, cmd_ready}, 32'd1);

    // Use word only, FB
    send(7'b0000000, 4'd0, 5'd10, 2'd0, 1'b1, 1'b1, 5'd3);
    collect(10);
    chk("t2_count", got.size(), 32'd1);
    if (got.size() == 1) begin
      chk("t2_instr", got[0], 32'h00B501AB);
      chk("t2_last", {31'd0, lastq[0]}, 32'd1);
    end
    @(negedge clk);

    // Grid count 0 -> 16 GRID_MUX words
    send(7'b0000010, 4'd0, 5'd0, 2'd0, 1'b0, 1'b0, 5'd0);
    collect(40);
    chk("t3_count", got.size(), 32'd16);
    if (got.size() == 16) begin
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("t3_w%0d", k), got[k],
            cw(3, 2 * k + 1, 2 * k, 0, 0));
        chk($sformatf("t3_l%0d", k), {31'd0, lastq[k]},
            (k == 15) ? 32'd1 : 32'd0);
      end
      chk("t3_rs1_15", {27'd0, got[15][19:15]}, 32'd30);
      chk("t3_rs2_15", {27'd0, got[15][24:20]}, 32'd31);
    end
    @(negedge clk);

    // Mixed: CPU_REG + 2x GRID_MUX, slot 3
    send(7'b0000011, 4'd2, 5'd0, 2'd3, 1'b0, 1'b0, 5'd0);
    collect(20);
    chk("t4_count", got.size(), 32'd3);
    if (got.size() == 3) begin
      chk("t4_w0", got[0], cw(2, 1, 0, 3, 0));
      chk("t4_w1", got[1], cw(3, 3, 2, 3, 0));
      chk("t4_w2", got[2], cw(3, 5, 4, 3, 0));
      chk("t4_l1", {31'd0, lastq[1]}, 32'd0);
      chk("t4_l2", {31'd0, lastq[2]}, 32'd1);
    end
    @(negedge clk);

    // Backpressure: CPU_REG, IO_MUX, use NFB
    send(7'b0000101, 4'd1, 5'd4, 2'd1, 1'b1, 1'b0, 5'd7);
    chk("t5_w0", instr, cw(2, 5, 4, 1, 0));
    @(negedge clk);
    chk("t5_w1", instr, cw(4, 7, 6, 1, 0));
    instr_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk($sformatf("t5_hold%0d", s), instr, cw(4, 7, 6, 1, 0));
      chk($sformatf("t5_hv%0d", s), {31'd0, instr_valid}, 32'd1);
      chk($sformatf("t5_hl%0d", s), {31'd0, instr_last}, 32'd0);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    chk("t5_use", instr, cw(1, 5, 4, 1, 7));
    chk("t5_last", {31'd0, instr_last}, 32'd1);
    @(negedge clk);
    chk("t5_done", {31'd0, done}, 32'd1);
    @(negedge clk);

    // LS_MASK bit alone
    send(7'b1000000, 4'd0, 5'd8, 2'd0, 1'b0, 1'b0, 5'd0);
    collect(10);
`ifdef RCA_CFG_LS_MASK_EN
    chk("t6_count", got.size(), 32'd1);
    if (got.size() == 1) chk("t6_w0", got[0], cw(8, 9, 8, 0, 0));
`else
    chk("t6_count", got.size(), 32'd0);
`endif
    @(negedge clk);

    // Empty command
    send(7'b0000000, 4'd0, 5'd0, 2'd0, 1'b0, 1'b0, 5'd0);
    chk("t7_done", {31'd0, done}, 32'd1);
    chk("t7_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk);

    // Reset during EMIT
    send(7'b0000010, 4'd0, 5'd0, 2'd0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    chk("t8_pre_valid", {31'd0, instr_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t8_valid", {31'd0, instr_valid}, 32'd0);
    chk("t8_instr", instr, 32'd0);
    chk("t8_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    hit_v = 1'b0;
    hit_d = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (instr_valid) hit_v = 1'b1;
      if (done) hit_d = 1'b1;
      @(negedge clk);
    end
    chk("t8_no_words", {31'd0, hit_v}, 32'd0);
    chk("t8_no_done", {31'd0, hit_d}, 32'd0);
    chk("t8_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Register wrap after reset
    send(7'b0000001, 4'd0, 5'd31, 2'd0, 1'b0, 1'b0, 5'd0);
    collect(10);
    chk("t9_count", got.size(), 32'd1);
    if (got.size() == 1) begin
      chk("t9_w0", got[0], cw(2, 0, 31, 0, 0));
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
